// File: rtl/raxi_rc512_disp_if.sv
// Handshake bundle between the RC receive FIFO read port, the dispatcher and its two
// downstream channels. The master modport is the dispatcher side.
interface raxi_rc512_disp_if;
    logic         rc_rx_ef;
    logic         rc_rx_rd;
    logic [539:0] rc_rx_rdata;
    logic         ch0_valid;
    logic         ch0_ready;
    logic         ch1_valid;
    logic         ch1_ready;
    logic [519:0] ch_data;
    logic         disp_busy;

    modport master (
        input  rc_rx_ef, rc_rx_rdata, ch0_ready, ch1_ready,
        output rc_rx_rd, ch0_valid, ch1_valid, ch_data, disp_busy
    );

    modport slave (
        output rc_rx_ef, rc_rx_rdata, ch0_ready, ch1_ready,
        input  rc_rx_rd, ch0_valid, ch1_valid, ch_data, disp_busy
    );
endinterface

// File: rtl/raxi_rc512_disp.sv
// RC completion dispatcher: pops 540-bit FIFO words and steers whole frames to ch0/ch1 by tag.
// Optional frame/error statistics outputs are enabled with `define RAXI_RC_DISP_STAT_EN.
module raxi_rc512_disp #(
    parameter int TAG_LSB    = 440,
    parameter int CH_SEL_BIT = 7,
    parameter int EOP_POS    = 519
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    raxi_rc512_disp_if.master       bus
`ifdef RAXI_RC_DISP_STAT_EN
    ,
    output logic [31:0]             ch0_frm_cnt,
    output logic [31:0]             ch1_frm_cnt,
    output logic [31:0]             err_frm_cnt
`endif
);

    localparam int ERR_POS = 518;

    typedef enum logic {
        ST_SOF  = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic         cur_ch_q, cur_ch_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         inflight_q, inflight_d;
    logic         disp_busy_q, disp_busy_d;

    // Two-entry in-order buffer: e0 is the head presented downstream, e1 the one behind it.
    logic         e0_vld_q, e0_vld_d;
    logic         e0_ch_q, e0_ch_d;
    logic [519:0] e0_data_q, e0_data_d;
    logic         e1_vld_q, e1_vld_d;
    logic         e1_ch_q, e1_ch_d;
    logic [519:0] e1_data_q, e1_data_d;

    logic         pop;
    logic         rd;
    logic         wr_ch;
    logic         wr_eop;
    logic [519:0] wr_data;
    logic         unused_rsv;

    assign pop = e0_vld_q & ((~e0_ch_q & bus.ch0_ready) | (e0_ch_q & bus.ch1_ready));

    // A pop in the same cycle frees a credit, so a full buffer still sustains one word per cycle.
    assign rd = ~user_rst & ~bus.rc_rx_ef & ((cnt_q != 2'd2) | pop);

    assign wr_data    = bus.rc_rx_rdata[519:0];
    assign wr_eop     = bus.rc_rx_rdata[EOP_POS];
    assign unused_rsv = ^bus.rc_rx_rdata[539:520];

    always_comb begin
        // NOTE: every _d is given its hold value first, so no path through this block leaves
        // a signal unassigned and no latch can be inferred.
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        cnt_d       = cnt_q + {1'b0, rd} - {1'b0, pop};
        inflight_d  = rd;
        e0_vld_d    = e0_vld_q;
        e0_ch_d     = e0_ch_q;
        e0_data_d   = e0_data_q;
        e1_vld_d    = e1_vld_q;
        e1_ch_d     = e1_ch_q;
        e1_data_d   = e1_data_q;
        wr_ch       = cur_ch_q;

        if (inflight_q) begin
            if (state_q == ST_SOF) begin
                wr_ch    = bus.rc_rx_rdata[TAG_LSB + CH_SEL_BIT];
                cur_ch_d = wr_ch;
            end
            state_d = wr_eop ? ST_SOF : ST_BODY;
        end

        if (pop) begin
            if (e1_vld_q) begin
                e0_ch_d   = e1_ch_q;
                e0_data_d = e1_data_q;
                e1_vld_d  = inflight_q;
                if (inflight_q) begin
                    e1_ch_d   = wr_ch;
                    e1_data_d = wr_data;
                end
            end else begin
                e0_vld_d = inflight_q;
                if (inflight_q) begin
                    e0_ch_d   = wr_ch;
                    e0_data_d = wr_data;
                end
            end
        end else if (inflight_q) begin
            // Credits bound occupancy to two, so e1 is always free when e0 is taken.
            if (!e0_vld_q) begin
                e0_vld_d  = 1'b1;
                e0_ch_d   = wr_ch;
                e0_data_d = wr_data;
            end else begin
                e1_vld_d  = 1'b1;
                e1_ch_d   = wr_ch;
                e1_data_d = wr_data;
            end
        end

        disp_busy_d = (state_d == ST_BODY);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values
    // computed before the edge, independent of statement order.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q     <= ST_SOF;
            cur_ch_q    <= 1'b0;
            cnt_q       <= 2'd0;
            inflight_q  <= 1'b0;
            disp_busy_q <= 1'b0;
            e0_vld_q    <= 1'b0;
            e0_ch_q     <= 1'b0;
            e0_data_q   <= '0;
            e1_vld_q    <= 1'b0;
            e1_ch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            disp_busy_q <= disp_busy_d;
            e0_vld_q    <= e0_vld_d;
            e0_ch_q     <= e0_ch_d;
            e0_data_q   <= e0_data_d;
            e1_vld_q    <= e1_vld_d;
            e1_ch_q     <= e1_ch_d;
        end
    end

    // NOTE: the second buffer slot's payload is never observed while e1_vld_q is low, so it
    // is left without reset; only the head payload is cleared because it drives ch_data.
    always_ff @(posedge user_clk) begin
        e1_data_q <= e1_data_d;
    end

    assign bus.rc_rx_rd  = rd;
    assign bus.ch0_valid = e0_vld_q & ~e0_ch_q;
    assign bus.ch1_valid = e0_vld_q & e0_ch_q;
    assign bus.ch_data   = e0_data_q;
    assign bus.disp_busy = disp_busy_q;

`ifdef RAXI_RC_DISP_STAT_EN
    logic [31:0] ch0_frm_cnt_q, ch0_frm_cnt_d;
    logic [31:0] ch1_frm_cnt_q, ch1_frm_cnt_d;
    logic [31:0] err_frm_cnt_q, err_frm_cnt_d;

    always_comb begin
        ch0_frm_cnt_d = ch0_frm_cnt_q;
        ch1_frm_cnt_d = ch1_frm_cnt_q;
        err_frm_cnt_d = err_frm_cnt_q;
        if (pop && e0_data_q[EOP_POS]) begin
            if (e0_ch_q) begin
                ch1_frm_cnt_d = ch1_frm_cnt_q + 32'd1;
            end else begin
                ch0_frm_cnt_d = ch0_frm_cnt_q + 32'd1;
            end
            if (e0_data_q[ERR_POS]) begin
                err_frm_cnt_d = err_frm_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            ch0_frm_cnt_q <= 32'd0;
            ch1_frm_cnt_q <= 32'd0;
            err_frm_cnt_q <= 32'd0;
        end else begin
            ch0_frm_cnt_q <= ch0_frm_cnt_d;
            ch1_frm_cnt_q <= ch1_frm_cnt_d;
            err_frm_cnt_q <= err_frm_cnt_d;
        end
    end

    assign ch0_frm_cnt = ch0_frm_cnt_q;
    assign ch1_frm_cnt = ch1_frm_cnt_q;
    assign err_frm_cnt = err_frm_cnt_q;
`endif

endmodule

// File: doc/raxi_rc512_disp.md
# raxi_rc512_disp

Completion dispatcher on the user-clock side of the 512-bit RC receive FIFO. Pops 540-bit frame words from the RC FIFO read port, decodes the completion tag on each frame's first word, and steers the whole frame to one of two downstream channels (ch0, ch1). A 2-entry output buffer with per-channel ready gives full single-beat throughput. A stalled channel backpressures the FIFO.

## Interface
Parameters:
- TAG_LSB, 440, LSB of the 8-bit completion tag in the first word of a frame (byte-swapped descriptor DW2).
- CH_SEL_BIT, 7, tag bit that selects the channel: 0 selects ch0, 1 selects ch1.
- EOP_POS, 519, end-of-frame bit in a FIFO word.

Ports:
- user_clk  in  1  the single clock.
- user_rst  in  1  reset, asynchronous, active-high.
- rc_rx_ef  in  1  RC FIFO empty.
- rc_rx_rd  out  1  RC FIFO read strobe. Data returns exactly 1 cycle later.
- rc_rx_rdata  in  540  RC FIFO read data. Bits 539:520 (rsv/parity) are ignored.
- ch0_valid  out  1  ch0 word valid.
- ch0_ready  in  1  ch0 accepts the word.
- ch1_valid  out  1  ch1 word valid.
- ch1_ready  in  1  ch1 accepts the word.
- ch_data  out  520  head word bits 519:0, shared by both channels: eop, err, mod[517:512], data[511:0].
- disp_busy  out  1  a frame is mid-dispatch (its SOF has been popped, its EOP has not).

## Operation
- Credit counter cnt (0..2) = buffered entries + read in flight.
- rc_rx_rd = !user_rst & !rc_rx_ef & (cnt<2 | pop). Here pop = (ch0_valid&ch0_ready)|(ch1_valid&ch1_ready).
- cnt_next = cnt + rd - pop.
- inflight register: set to rc_rx_rd each cycle. When inflight=1, rc_rx_rdata[519:0] and the channel are written to the buffer tail.
- Frame FSM (on written words):
  - SOF: take the channel from rc_rx_rdata[TAG_LSB+CH_SEL_BIT] and latch it into cur_ch. If EOP_POS=1, stay in SOF; otherwise go to BODY.
  - BODY: use cur_ch. If EOP_POS=1, go to SOF.
- Single-word frames (sof=eop) are legal.
- The buffer is a 2-entry in-order FIFO. Only the head is presented. chN_valid = head_vld & (head_ch==N). The other channel's valid stays 0.
- No reordering: a stalled channel blocks the other channel.
- The err bit (518) is passed through unchanged. Error frames are not dropped here.
- disp_busy = (FSM==BODY).

## Timing
- Reset values: rc_rx_rd=0, ch0_valid=0, ch1_valid=0, ch_data=0, disp_busy=0, cnt=0, inflight=0, FSM=SOF. Stat counters, when present, reset to 0.
- rc_rx_rd is combinational from registered state and rc_rx_ef.
- Latency: rd at cycle t, data captured at t+1, chN_valid at t+2 (empty buffer).
- Steady state with the consumer always ready: one word per cycle.
- valid/ready: once valid is high, it and ch_data stay stable until ready. A transfer occurs when both are high.
- Full buffer (cnt=2) with no pop: rd=0. With a pop in the same cycle: rd may assert.
- Empty FIFO: rd=0. No bubble words are ever written.
- Reset mid-frame: the buffer is flushed and the FSM returns to SOF. The next popped word is treated as SOF.

## Configuration
- RAXI_RC_DISP_STAT_EN:
  - Defined: adds outputs ch0_frm_cnt[31:0] and ch1_frm_cnt[31:0]. Each increments on an accepted word with eop=1 on that channel and wraps at 2^32.
  - Also adds err_frm_cnt[31:0], incremented on an accepted eop word with err=1 on either channel.
  - Undefined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Single 1-word frame, tag=0x05, both readies=1 -> rd 1 cycle, ch0_valid for 1 cycle at t+2, ch_data[519]=1, ch1_valid=0.
- 4-word frame, tag=0x85, ch1_ready=1 -> 4 consecutive rd cycles, ch1_valid for 4 consecutive cycles, disp_busy high from the 1st through the 3rd accepted word.
- Back-to-back frames (tag 0x01, 3 words; tag 0x81, 2 words) with ch0_ready held 0 for 10 cycles -> exactly 2 rd pulses then rd=0, ch1_valid=0 until all ch0 words are accepted, then the ch1 frame follows with no loss.
- ch_data stability: ready toggles 1/0 every cycle during an 8-word frame -> ch_data constant while valid&!ready, 8 words delivered in order, cnt never exceeds 2.
- Reset asserted mid-frame (after word 2 of 5) -> all outputs 0 immediately. After release, the next word's tag selects the channel.
- With RAXI_RC_DISP_STAT_EN: 3 ch0 frames, 2 ch1 frames, 1 with err=1 -> ch0_frm_cnt=3, ch1_frm_cnt=2, err_frm_cnt=1.
